int_arbiter: RTL and testbench
==============================

# int_arbiter

Priority interrupt arbiter that sits between the board-level `hardware_interrupt` lines and the coprocessor 0 exception logic. It turns raw interrupt levels into latched edge-triggered pending requests and applies per-line and global enables. It picks the highest-priority eligible line, supports nesting by priority, and presents one request at a time to cp0 over a req/ack handshake, together with the handler's word-addressed vector. `eret` from the control unit retires the innermost in-service level.

## Interface

- `N_IRQ`, 8, number of interrupt lines; line 0 is highest priority.
- `VEC_BASE`, 32'h0000_0100, word address of the line-0 handler.
- `VEC_STRIDE`, 32'h0000_0010, word distance between consecutive handler vectors.

- `clk` in 1: single clock; all state updates on posedge.
- `clr` in 1: reset, synchronous, active-high.
- `hardware_interrupt` in N_IRQ: raw interrupt levels, already synchronous to `clk`.
- `mask` in N_IRQ: per-line enable, 1 = enabled (cp0 status IM field).
- `global_en` in 1: global interrupt enable (cp0 status IE).
- `irq_ack` in 1: cp0 takes the presented interrupt this cycle.
- `eret` in 1: handler return executed this cycle.
- `irq_req` out 1: a request is presented to cp0.
- `irq_num` out $clog2(N_IRQ): number of the presented line.
- `irq_vector` out 32: handler word address for `irq_num`.
- `pending` out N_IRQ: latched, not-yet-acknowledged edges.
- `in_service` out N_IRQ: lines whose handlers are active (nesting stack).

## Operation

- Edge detect: `prev` register holds last sample. `hardware_interrupt[i] & ~prev[i]` sets `pending[i]`. Levels are otherwise ignored.
- Eligible set: `pending & mask`, gated by `global_en`.
  - Candidate = lowest-index eligible bit.
  - Current level = lowest-index `in_service` bit, or none.
  - The candidate is valid only if it is strictly higher priority (lower index) than the current level.
- FSM, two states:
  - IDLE: `irq_req`=0. Goes to REQ on a valid candidate; latches `irq_num` and `irq_vector` = VEC_BASE + num*VEC_STRIDE (32-bit, wraps modulo 2^32).
  - REQ: `irq_req`=1, and `irq_num`/`irq_vector` stay frozen. Stays until `irq_ack`; there is no withdrawal.
    - A higher-priority arrival does not replace the presented line.
    - A change to `mask` or `global_en` does not drop the request.
  - On `irq_ack` in REQ: clear `pending[irq_num]`, set `in_service[irq_num]`, return to IDLE.
- `irq_ack` in IDLE is ignored.
- `eret`: clears the lowest-index set `in_service` bit. With `in_service`=0 it has no effect. It is honoured in either state.
- Simultaneous events in one cycle:
  - `eret`+`irq_ack`: `eret` clears a bit of the old `in_service`, then the acknowledged bit is set.
  - New edge and `irq_ack` on the same line: `pending` stays 1 (the new edge is kept).
  - Edge on a line already in service: pending is set and serviced only after its `eret`.
- Reset: `prev`, `pending`, `in_service`, `irq_num` = 0; `irq_vector` = VEC_BASE; `irq_req` = 0; state = IDLE.
  - `clr` mid-handshake drops the request and discards all pending and in-service state.
  - A line still high on the first cycle after `clr` registers as an edge, because `prev` resets to 0.

## Timing

- Edge sampled high at posedge E0 (prev 0): `pending` is set after E0, and `irq_req`, `irq_num`, `irq_vector` are valid after E1. Latency is 2 edges.
- `irq_ack` sampled at Ek: `irq_req`=0 after Ek. The earliest next request is valid after Ek+1, giving at least one idle cycle between requests.
- `eret` sampled at Ek: `in_service` is updated after Ek. A lower-priority pending line can be requested after Ek+1.
- All outputs are registered; there are no combinational paths from inputs to `irq_req`, `irq_num` or `irq_vector`.

## Structure

- Package `int_arbiter_pkg` holds:
  - the FSM state enum (`ARB_IDLE`, `ARB_REQ`);
  - the default `VEC_BASE` and `VEC_STRIDE` constants.
- Sub-module `prio_enc`: parameterised lowest-index-set-bit encoder with a `valid` output. It is instantiated twice, once for the eligible set and once for `in_service`.

## Test plan

- Single line: pulse line 3 with mask=8'hFF, global_en=1 → `irq_req`=1 two edges later with `irq_num`=3 and `irq_vector`=32'h130. Ack → `pending`=0, `in_service`=8'h08.
- Priority: lines 5 and 2 rise in the same cycle → line 2 is presented first. After ack+`eret`, line 5 is presented; after its `eret`, `in_service`=0.
- Nesting: line 4 in service, line 1 rises → request for 1 (nested), giving `in_service`=8'h12. Line 6 rising while 4 is in service → no request until both `eret`s.
- Gating: global_en=0 or mask[2]=0 with line 2 pending → `irq_req` stays 0. Re-enabling → request after 1 edge. Clearing mask while in REQ → request held until ack.
- Simultaneity: new edge on line 3 in the same cycle as its ack → `pending[3]` stays 1. `eret` and ack in the same cycle → the old bit is cleared and the new bit is set.
- Reset: `clr` asserted during REQ → next cycle all outputs are at reset values. A line held high through `clr` → `pending` set on the first cycle after release.

Source files
------------

// File: rtl/int_arbiter_pkg.sv
// Shared types and constants for the priority interrupt arbiter.
// Holds the FSM state encoding, the default vector layout and the vector address helper.
package int_arbiter_pkg;

    typedef enum logic {
        ARB_IDLE = 1'b0,
        ARB_REQ  = 1'b1
    } arb_state_t;

    localparam logic [31:0] VEC_BASE_DEF   = 32'h0000_0100;
    localparam logic [31:0] VEC_STRIDE_DEF = 32'h0000_0010;

    // Handler word address; wraps modulo 2^32 by construction.
    function automatic logic [31:0] vec_addr(input logic [31:0] base,
                                             input logic [31:0] stride,
                                             input logic [31:0] num);
        return base + stride * num;
    endfunction

endpackage

// File: rtl/int_arbiter_prio_enc.sv
// Lowest-index-set-bit encoder; index 0 has the highest priority.
// The valid output is low when no request bit is set, in which case idx is 0.
module prio_enc #(
    parameter int N = 8
) (
    input  logic [N-1:0]         req,
    output logic                 valid,
    output logic [$clog2(N)-1:0] idx
);

    localparam int IDX_W = $clog2(N);

    always_comb begin
        valid = |req;
        idx   = '0;
        // Scanning downward lets the lowest set index overwrite the others.
        for (int i = N - 1; i >= 0; i--) begin
            if (req[i]) begin
                idx = IDX_W'(i);
            end
        end
    end

endmodule

// File: rtl/int_arbiter.sv
// Priority interrupt arbiter: edge-latched pending lines, per-line and global enables,
// nesting by priority, and a single req/ack handshake towards cp0 with the handler vector.
module int_arbiter
    import int_arbiter_pkg::*;
#(
    parameter int          N_IRQ      = 8,
    parameter logic [31:0] VEC_BASE   = VEC_BASE_DEF,
    parameter logic [31:0] VEC_STRIDE = VEC_STRIDE_DEF
) (
    input  logic                     clk,
    input  logic                     clr,
    input  logic [N_IRQ-1:0]         hardware_interrupt,
    input  logic [N_IRQ-1:0]         mask,
    input  logic                     global_en,
    input  logic                     irq_ack,
    input  logic                     eret,
    output logic                     irq_req,
    output logic [$clog2(N_IRQ)-1:0] irq_num,
    output logic [31:0]              irq_vector,
    output logic [N_IRQ-1:0]         pending,
    output logic [N_IRQ-1:0]         in_service
);

    localparam int NUM_W = $clog2(N_IRQ);
    localparam logic [N_IRQ-1:0] ONE_HOT0 = N_IRQ'(1);

    arb_state_t         state;
    arb_state_t         state_nxt;
    logic [N_IRQ-1:0]   prev;
    logic [N_IRQ-1:0]   rise;
    logic [N_IRQ-1:0]   eligible;
    logic [N_IRQ-1:0]   ack_bit;
    logic [N_IRQ-1:0]   eret_bit;
    logic               cand_vld;
    logic [NUM_W-1:0]   cand_idx;
    logic               cur_vld;
    logic [NUM_W-1:0]   cur_idx;
    logic               cand_ok;
    logic               load_req;
    logic               take_ack;

    assign rise     = hardware_interrupt & ~prev;
    assign eligible = global_en ? (pending & mask) : '0;

    prio_enc #(.N(N_IRQ)) u_cand_enc (
        .req   (eligible),
        .valid (cand_vld),
        .idx   (cand_idx)
    );

    prio_enc #(.N(N_IRQ)) u_cur_enc (
        .req   (in_service),
        .valid (cur_vld),
        .idx   (cur_idx)
    );

    // Nesting only admits a strictly more urgent line than the innermost handler.
    assign cand_ok = cand_vld && (!cur_vld || (cand_idx < cur_idx));

    always_ff @(posedge clk) begin
        if (clr) begin
            state <= ARB_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ARB_IDLE: if (cand_ok) state_nxt = ARB_REQ;
            ARB_REQ:  if (irq_ack) state_nxt = ARB_IDLE;
            default:  state_nxt = ARB_IDLE;
        endcase
    end

    always_comb begin
        irq_req  = 1'b0;
        load_req = 1'b0;
        take_ack = 1'b0;
        case (state)
            ARB_IDLE: load_req = cand_ok;
            ARB_REQ: begin
                irq_req  = 1'b1;
                take_ack = irq_ack;
            end
            default: ;
        endcase
    end

    assign ack_bit  = take_ack ? (ONE_HOT0 << irq_num) : '0;
    assign eret_bit = (eret && cur_vld) ? (ONE_HOT0 << cur_idx) : '0;

    // A fresh edge wins over the ack clear, and eret acts on the old in-service set.
    always_ff @(posedge clk) begin
        if (clr) begin
            prev       <= '0;
            pending    <= '0;
            in_service <= '0;
            irq_num    <= '0;
            irq_vector <= VEC_BASE;
        end else begin
            prev       <= hardware_interrupt;
            pending    <= (pending & ~ack_bit) | rise;
            in_service <= (in_service & ~eret_bit) | ack_bit;
            if (load_req) begin
                irq_num    <= cand_idx;
                irq_vector <= vec_addr(VEC_BASE, VEC_STRIDE, 32'(cand_idx));
            end
        end
    end

endmodule

// File: tb/tb_int_arbiter.sv
// Self-checking bench for int_arbiter: directed vector table, hand-written corner
// sequences and randomized traffic compared against a cycle-level reference model.
module tb_int_arbiter;

    logic       clk = 1'b0;
    logic       clr;
    logic [7:0] hardware_interrupt;
    logic [7:0] mask;
    logic       global_en;
    logic       irq_ack;
    logic       eret;
    logic       irq_req;
    logic [2:0] irq_num;
    logic [31:0] irq_vector;
    logic [7:0] pending;
    logic [7:0] in_service;

    int n_checks = 0;
    int n_errors = 0;

    int_arbiter #(.N_IRQ(8)) dut (
        .clk                (clk),
        .clr                (clr),
        .hardware_interrupt (hardware_interrupt),
        .mask               (mask),
        .global_en          (global_en),
        .irq_ack            (irq_ack),
        .eret               (eret),
        .irq_req            (irq_req),
        .irq_num            (irq_num),
        .irq_vector         (irq_vector),
        .pending            (pending),
        .in_service         (in_service)
    );

    always #5 clk = ~clk;

    // Reference model state
    bit [7:0]  m_prev, m_pend, m_is;
    bit        m_req;
    int        m_num;
    bit [31:0] m_vec;

    function automatic int lowest(input bit [7:0] v);
        for (int i = 0; i < 8; i++) if (v[i]) return i;
        return 8;
    endfunction

    task automatic model_step(input bit c, input bit [7:0] h, input bit [7:0] m,
                              input bit g, input bit a, input bit e);
        bit [7:0] elig, npend, nis;
        int cand, cur;
        if (c) begin
            m_prev = 0; m_pend = 0; m_is = 0; m_req = 0; m_num = 0; m_vec = 32'h100;
        end else begin
            elig = g ? (m_pend & m) : 8'h00;
            cand = lowest(elig);
            cur  = lowest(m_is);
            nis  = m_is;
            npend = m_pend;
            if (e && cur < 8) nis[cur] = 1'b0;
            if (m_req) begin
                if (a) begin
                    npend[m_num] = 1'b0;
                    nis[m_num]   = 1'b1;
                    m_req        = 1'b0;
                end
            end else if (cand < cur) begin
                m_req = 1'b1;
                m_num = cand;
                m_vec = 32'h100 + 32'(cand) * 32'h10;
            end
            npend  = npend | (h & ~m_prev);
            m_pend = npend;
            m_is   = nis;
            m_prev = h;
        end
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic check_model();
        chk("req",        32'(irq_req),    32'(m_req));
        chk("pending",    32'(pending),    32'(m_pend));
        chk("in_service", 32'(in_service), 32'(m_is));
        chk("num",        32'(irq_num),    32'(m_num));
        chk("vector",     irq_vector,      m_vec);
    endtask

    task automatic cyc(input bit c, input bit [7:0] h, input bit [7:0] m,
                       input bit g, input bit a, input bit e);
        clr = c; hardware_interrupt = h; mask = m; global_en = g; irq_ack = a; eret = e;
        @(posedge clk);
        model_step(c, h, m, g, a, e);
        #1;
    endtask

    typedef struct {
        bit        c;
        bit [7:0]  h;
        bit        a;
        bit        e;
        bit        x_req;
        bit [2:0]  x_num;
        bit [31:0] x_vec;
        bit [7:0]  x_pend;
        bit [7:0]  x_is;
    } vec_t;

    vec_t tbl[14];

    initial begin
        //           clr  hw     ack  eret req num vec        pend   is
        tbl[0]  = '{1'b1, 8'h00, 1'b0, 1'b0, 1'b0, 3'd0, 32'h100, 8'h00, 8'h00};
        tbl[1]  = '{1'b0, 8'h08, 1'b0, 1'b0, 1'b0, 3'd0, 32'h100, 8'h08, 8'h00};
        tbl[2]  = '{1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 3'd3, 32'h130, 8'h08, 8'h00};
        tbl[3]  = '{1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 3'd3, 32'h130, 8'h00, 8'h08};
        tbl[4]  = '{1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 3'd3, 32'h130, 8'h00, 8'h00};
        tbl[5]  = '{1'b0, 8'h24, 1'b0, 1'b0, 1'b0, 3'd3, 32'h130, 8'h24, 8'h00};
        tbl[6]  = '{1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 3'd2, 32'h120, 8'h24, 8'h00};
        tbl[7]  = '{1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 3'd2, 32'h120, 8'h20, 8'h04};
        tbl[8]  = '{1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 3'd2, 32'h120, 8'h20, 8'h04};
        tbl[9]  = '{1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 3'd2, 32'h120, 8'h20, 8'h00};
        tbl[10] = '{1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 3'd5, 32'h150, 8'h20, 8'h00};
        tbl[11] = '{1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 3'd5, 32'h150, 8'h00, 8'h20};
        tbl[12] = '{1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 3'd5, 32'h150, 8'h00, 8'h00};
        tbl[13] = '{1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 3'd5, 32'h150, 8'h00, 8'h00};

        clr = 1'b1; hardware_interrupt = 8'h00; mask = 8'hFF; global_en = 1'b1;
        irq_ack = 1'b0; eret = 1'b0;
        m_prev = 0; m_pend = 0; m_is = 0; m_req = 0; m_num = 0; m_vec = 32'h100;

        // Directed table: single line, then two simultaneous lines by priority
        for (int i = 0; i < 14; i++) begin
            cyc(tbl[i].c, tbl[i].h, 8'hFF, 1'b1, tbl[i].a, tbl[i].e);
            chk($sformatf("tbl%0d_req", i),  32'(irq_req),    32'(tbl[i].x_req));
            chk($sformatf("tbl%0d_num", i),  32'(irq_num),    32'(tbl[i].x_num));
            chk($sformatf("tbl%0d_vec", i),  irq_vector,      tbl[i].x_vec);
            chk($sformatf("tbl%0d_pend", i), 32'(pending),    32'(tbl[i].x_pend));
            chk($sformatf("tbl%0d_is", i),   32'(in_service), 32'(tbl[i].x_is));
        end

        // Nesting: 4 in service, 1 nests, 6 waits for both erets
        cyc(1, 8'h00, 8'hFF, 1, 0, 0);
        cyc(0, 8'h10, 8'hFF, 1, 0, 0);
        cyc(0, 8'h00, 8'hFF, 1, 0, 0); chk("nest_req4", 32'(irq_num), 32'd4);
        cyc(0, 8'h00, 8'hFF, 1, 1, 0);
        cyc(0, 8'h02, 8'hFF, 1, 0, 0);
        cyc(0, 8'h00, 8'hFF, 1, 0, 0); chk("nest_req1", 32'({irq_req, irq_num}), 32'h9);
        cyc(0, 8'h00, 8'hFF, 1, 1, 0); chk("nest_is", 32'(in_service), 32'h12);
        cyc(0, 8'h40, 8'hFF, 1, 0, 0);
        cyc(0, 8'h00, 8'hFF, 1, 0, 0); chk("nest_6_blocked", 32'(irq_req), 32'd0);
        cyc(0, 8'h00, 8'hFF, 1, 0, 1); check_model();
        cyc(0, 8'h00, 8'hFF, 1, 0, 0); chk("nest_6_still_blocked", 32'(irq_req), 32'd0);
        cyc(0, 8'h00, 8'hFF, 1, 0, 1); chk("nest_is_clear", 32'(in_service), 32'h00);
        cyc(0, 8'h00, 8'hFF, 1, 0, 0); chk("nest_req6", 32'({irq_req, irq_num}), 32'hE);
        cyc(0, 8'h00, 8'hFF, 1, 1, 0);
        cyc(0, 8'h00, 8'hFF, 1, 0, 1); check_model();

        // Gating: global_en then mask hold off line 2; mask clear during REQ keeps request
        cyc(0, 8'h04, 8'hFF, 0, 0, 0);
        cyc(0, 8'h00, 8'hFF, 0, 0, 0);
        cyc(0, 8'h00, 8'hFF, 0, 0, 0); chk("gate_ge", 32'(irq_req), 32'd0);
        cyc(0, 8'h00, 8'hFB, 1, 0, 0);
        cyc(0, 8'h00, 8'hFB, 1, 0, 0); chk("gate_mask", 32'(irq_req), 32'd0);
        cyc(0, 8'h00, 8'hFF, 1, 0, 0); chk("gate_reenable", 32'({irq_req, irq_num}), 32'hA);
        cyc(0, 8'h00, 8'h00, 0, 0, 0);
        cyc(0, 8'h01, 8'h00, 0, 0, 0); chk("gate_hold", 32'({irq_req, irq_num}), 32'hA);
        cyc(0, 8'h00, 8'h00, 0, 1, 0); chk("gate_ack_is", 32'(in_service), 32'h04);
        check_model();

        // Simultaneity: edge with ack on line 3, then eret together with ack
        cyc(1, 8'h00, 8'hFF, 1, 0, 0);
        cyc(0, 8'h08, 8'hFF, 1, 0, 0);
        cyc(0, 8'h00, 8'hFF, 1, 0, 0); chk("sim_req3", 32'({irq_req, irq_num}), 32'hB);
        cyc(0, 8'h08, 8'hFF, 1, 1, 0);
        chk("sim_pend3", 32'(pending), 32'h08);
        chk("sim_is3", 32'(in_service), 32'h08);
        cyc(0, 8'h02, 8'hFF, 1, 0, 0);
        cyc(0, 8'h00, 8'hFF, 1, 0, 0); chk("sim_req1", 32'({irq_req, irq_num}), 32'h9);
        cyc(0, 8'h00, 8'hFF, 1, 1, 1); chk("sim_eret_ack", 32'(in_service), 32'h02);
        check_model();

        // Reset mid-handshake with a line held high across clr
        cyc(0, 8'h00, 8'hFF, 1, 0, 1);
        cyc(0, 8'h00, 8'hFF, 1, 0, 0); chk("rst_pre_req", 32'(irq_req), 32'd1);
        cyc(1, 8'h01, 8'hFF, 1, 0, 0);
        chk("rst_req", 32'(irq_req), 32'd0);
        chk("rst_vec", irq_vector, 32'h100);
        chk("rst_pend", 32'({pending, in_service, 5'd0, irq_num}), 32'h0);
        cyc(0, 8'h01, 8'hFF, 1, 0, 0); chk("rst_held_edge", 32'(pending), 32'h01);
        cyc(0, 8'h01, 8'hFF, 1, 0, 0); chk("rst_held_req", 32'({irq_req, irq_num}), 32'h8);
        check_model();

        // Randomized traffic against the reference model
        for (int n = 0; n < 3000; n++) begin
            bit [7:0] h, m;
            h = 8'($urandom) & 8'($urandom) & 8'($urandom);
            m = ($urandom_range(0, 7) == 0) ? 8'($urandom) : 8'hFF;
            cyc($urandom_range(0, 199) == 0, h, m, $urandom_range(0, 9) != 0,
                $urandom_range(0, 2) == 0, $urandom_range(0, 5) == 0);
            check_model();
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
